// File: rtl/clock_irq.sv
// Interrupt unit for the clock/timer peripheral: latches the prescaler tick and
// counter-zero edges as pending events, then masks and gates them into one registered irq.
module clock_irq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  input  logic             cs,
  output logic [WIDTH-1:0] dout,
  input  logic             tick,
  input  logic [15:0]      zero,
  output logic             irq
);

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_CTRL = 2'd2,
    REG_ID   = 2'd3
  } reg_sel_e;

  reg_sel_e    sel;
  logic        wr;
  logic [15:0] pend;
  logic [15:0] mask;
  logic        en;
  logic [15:2] zprev;
  logic [15:0] set;
  logic [15:0] clr;
  logic [15:0] masked;
  logic [4:0]  id_idx;
  logic [WIDTH-1:0] id_reg;

  // Upper address/data bits and zero[1:0] carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{addr[WIDTH-1:2], din[WIDTH-1:16], zero[1:0]};

  assign sel    = reg_sel_e'(addr[1:0]);
  assign wr     = cs & wen;
  assign masked = pend & mask;

  assign set[0]    = tick;
  assign set[1]    = tick & pend[0];
  assign set[15:2] = zero[15:2] & ~zprev;
  assign clr       = (wr && sel == REG_PEND) ? din[15:0] : 16'h0000;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    id_idx = 5'h1F;
    // Scanning downward lets the lowest set bit overwrite higher ones.
    for (int i = 15; i >= 0; i--) begin
      if (masked[i]) id_idx = 5'(i);
    end
  end

  always_comb begin
    id_reg          = '0;
    id_reg[4:0]     = id_idx;
    id_reg[WIDTH-1] = |masked;
  end

  always_comb begin
    dout = '0;
    unique case (sel)
      REG_PEND: dout[15:0] = pend;
      REG_MASK: dout[15:0] = mask;
      REG_CTRL: dout[0]    = en;
      REG_ID:   dout       = id_reg;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend  <= '0;
      mask  <= '0;
      en    <= 1'b0;
      irq   <= 1'b0;
      // Timer counters come out of reset at zero; all-ones here suppresses a false edge.
      zprev <= '1;
    end else begin
      zprev <= zero[15:2];
      pend  <= set | (pend & ~clr);
      irq   <= en & (|masked);
      if (wr && sel == REG_MASK) mask <= din[15:0];
      if (wr && sel == REG_CTRL) en   <= din[0];
    end
  end

endmodule

// File: tb/tb_clock_irq.sv
// Directed self-checking bench for clock_irq: capture, overrun, edge detect,
// set-vs-clear priority, masking/enable latency and asynchronous reset.
module tb_clock_irq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] din;
  logic             wen;
  logic             cs;
  logic [WIDTH-1:0] dout;
  logic             tick;
  logic [15:0]      zero;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  clock_irq #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .din  (din),
    .wen  (wen),
    .cs   (cs),
    .dout (dout),
    .tick (tick),
    .zero (zero),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = {30'd0, a};
    din  = d;
    cs   = 1'b1;
    wen  = 1'b1;
    step(1);
    cs   = 1'b0;
    wen  = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = {30'd0, a};
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    reset = 1'b0;
    addr  = '0;
    din   = '0;
    wen   = 1'b0;
    cs    = 1'b0;
    tick  = 1'b0;
    zero  = 16'hFFFC;

    // Reset release with all counters already at zero
    step(2);
    reset = 1'b1;
    step(10);
    check_reg("rst_pend", 2'd0, 32'h0000_0000);
    check_reg("rst_mask", 2'd1, 32'h0000_0000);
    check_reg("rst_ctrl", 2'd2, 32'h0000_0000);
    check_reg("rst_id",   2'd3, 32'h0000_001F);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Single tick: PEND at n+1, irq at n+2, W1C drops irq two edges later
    bus_write(2'd1, 32'h0000_0001);
    bus_write(2'd2, 32'h0000_0001);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check_reg("tick_pend", 2'd0, 32'h0000_0001);
    check("tick_irq_n1", {31'd0, irq}, 32'd0);
    step(1);
    check("tick_irq_n2", {31'd0, irq}, 32'd1);
    check_reg("tick_id", 2'd3, 32'h8000_0000);
    bus_write(2'd0, 32'h0000_0001);
    check_reg("w1c_pend", 2'd0, 32'h0000_0000);
    check("w1c_irq_e1", {31'd0, irq}, 32'd1);
    step(1);
    check("w1c_irq_e2", {31'd0, irq}, 32'd0);

    // Overrun: second tick before acknowledge
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check_reg("ovr_pend", 2'd0, 32'h0000_0003);
    check_reg("ovr_id",   2'd3, 32'h8000_0000);
    bus_write(2'd0, 32'h0000_0003);
    check_reg("ovr_clr", 2'd0, 32'h0000_0000);

    // zero[5] edge detection
    zero = 16'h0000;
    step(2);
    check_reg("fall_pend", 2'd0, 32'h0000_0000);
    bus_write(2'd1, 32'h0000_0020);
    zero[5] = 1'b1;
    step(1);
    check_reg("z5_pend", 2'd0, 32'h0000_0020);
    check_reg("z5_id",   2'd3, 32'h8000_0005);
    step(20);
    check_reg("z5_hold", 2'd0, 32'h0000_0020);
    bus_write(2'd0, 32'h0000_0020);
    step(5);
    check_reg("z5_noreset", 2'd0, 32'h0000_0000);
    zero[5] = 1'b0;
    step(1);
    zero[5] = 1'b1;
    step(1);
    check_reg("z5_reraise", 2'd0, 32'h0000_0020);
    bus_write(2'd0, 32'h0000_0020);

    // Set beats a simultaneous W1C of the same bit
    addr = 32'd0;
    din  = 32'h0000_0001;
    cs   = 1'b1;
    wen  = 1'b1;
    tick = 1'b1;
    step(1);
    cs   = 1'b0;
    wen  = 1'b0;
    tick = 1'b0;
    check_reg("set_wins", 2'd0, 32'h0000_0001);
    bus_write(2'd0, 32'h0000_FFFF);

    // Masked ID with EN off, then enable latency, then async reset
    bus_write(2'd2, 32'h0000_0000);
    bus_write(2'd1, 32'h0000_0C00);
    zero = 16'h0C24;
    step(1);
    check_reg("multi_pend", 2'd0, 32'h0000_0C04);
    step(1);
    check("en0_irq", {31'd0, irq}, 32'd0);
    check_reg("multi_id", 2'd3, 32'h8000_000A);
    bus_write(2'd2, 32'h0000_0001);
    check("en_irq_e1", {31'd0, irq}, 32'd0);
    step(1);
    check("en_irq_e2", {31'd0, irq}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq}, 32'd0);
    check_reg("arst_pend", 2'd0, 32'h0000_0000);
    check_reg("arst_mask", 2'd1, 32'h0000_0000);
    check_reg("arst_ctrl", 2'd2, 32'h0000_0000);
    step(1);
    reset = 1'b1;
    step(3);
    check_reg("post_rst_pend", 2'd0, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_irq.md
Name: clock_irq

Overview:
- Memory-mapped interrupt unit directly downstream of the clock/timer peripheral.
- Consumes the timer's prescaler tick pulse and the 14 backward-counter "zero" levels, and latches them as pending events.
- Applies a mask and a global enable, and drives one registered interrupt request to the CPU.
- Sits on the same peripheral bus as the timer: addr/din/wen/cs in, combinational dout.

Parameters:
- WIDTH, 32, bus data/address width; must be >= 16.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- addr  input  WIDTH  bus address; only addr[1:0] decoded, upper bits ignored
- din  input  WIDTH  bus write data
- wen  input  1  write enable, qualified by cs
- cs  input  1  chip select for this block
- dout  output  WIDTH  read data, combinational from addr[1:0]
- tick  input  1  one-cycle pulse from timer each time the prescaler expires (timer clock increments)
- zero  input  16  bit i (i=2..15) high while backward counter i equals 0; bits 1:0 unused, ignored
- irq  output  1  registered interrupt request to CPU

Behaviour:
- Registers, selected by addr[1:0]:
  - 0 PEND: bits 15:0 pending, write-1-to-clear.
  - 1 MASK: bits 15:0, read/write.
  - 2 CTRL: bit0 EN, read/write.
  - 3 ID: read-only; writes ignored.
  - Unused upper bits read 0.
- Write strobe wr = cs & wen; a write takes effect on the next rising clk.
- Reset (reset=0, async): PEND=0, MASK=0, EN=0, irq=0, zprev[15:2]=all ones.
  - zprev=1 after reset prevents spurious edges, since the timer's counters reset to 0 and hold zero high.
- Edge detect: zprev[i] <= zero[i] every cycle. set[i] = zero[i] & ~zprev[i] for i=2..15, a 0->1 transition.
  - A counter already at 0 or staying at 0 generates no new event.
- set[0] = tick.
- set[1] = tick & PEND[0] (overrun: tick arrived while the previous tick is still unacknowledged).
- Pending update per bit, every cycle: PEND[i] <= set[i] | (PEND[i] & ~(wr & sel0 & din[i])).
  - Set has priority over a simultaneous W1C of the same bit; the bit stays 1.
- Event capture ignores MASK and EN: masked events still latch in PEND.
- ID register:
  - bits 4:0 = index of the lowest-numbered bit of (PEND & MASK), or 5'h1F if none.
  - bit 31 (WIDTH-1) = (PEND & MASK) != 0.
  - Combinational from current register values.
- irq <= EN & |(PEND & MASK), registered.
  - Latency: event on cycle n, PEND set at edge n+1, irq high at edge n+2.
  - Clearing the last masked pending bit drops irq 2 edges after the write cycle; clearing MASK or EN behaves the same.
- irq is level-type: stays high until software clears the cause, masks it, or clears EN.
- dout = selected register per addr[1:0], independent of cs (matches timer read convention).
- Reset mid-operation: async clear of all state regardless of clk; first edge after release has no events from zero inputs already high.

Test Plan:
- Reset release with zero=16'hFFFC held high; run 10 cycles -> PEND=0, irq=0, ID=0x0000001F.
- MASK=16'h0001, EN=1; pulse tick once at cycle n -> PEND=0x1 after edge n+1; irq=1 at edge n+2; ID=0x80000000. Write PEND=0x1 -> irq=0 two edges later.
- Second tick without clearing PEND[0] -> PEND=0x3 (overrun bit 1 set); with MASK=0x1, ID still reports 0.
- zero[5] goes 0->1 and stays high 20 cycles, MASK=0x20 -> PEND[5] set once. W1C 0x20 while zero[5] stays high -> PEND[5]=0, no re-set. Drop and re-raise zero[5] -> PEND[5]=1 again.
- Same cycle: tick=1 and W1C write of 0x1 to PEND -> PEND[0]=1 after the edge (set wins).
- PEND=0x0C04, MASK=0x0C00, EN=0 -> irq=0, ID=0x8000000A. Set EN=1 -> irq=1 two edges after the write. Assert reset=0 asynchronously mid-cycle -> irq, PEND, MASK, EN all 0 immediately.
